// File: rtl/bitonic_out_serializer.sv
// Captures one sorted 8-word vector from the bitonic merge stage and streams it out one word per beat.
// Optional build macro SER_DESC_EN: emit words largest first (beat j carries buf[7-j]).
module bitonic_out_serializer #(
    parameter int DATA_W = 8,
    parameter int NUM    = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] number_in1,
    input  logic [DATA_W-1:0] number_in2,
    input  logic [DATA_W-1:0] number_in3,
    input  logic [DATA_W-1:0] number_in4,
    input  logic [DATA_W-1:0] number_in5,
    input  logic [DATA_W-1:0] number_in6,
    input  logic [DATA_W-1:0] number_in7,
    input  logic [DATA_W-1:0] number_in8,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] number_out,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              sort_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] buf_r [NUM];
    logic              sort_err_r;
    logic              capture_s;
    logic              in_ready_s;
    logic              last_beat_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [NUM*DATA_W-1:0] in_flat_s;

    // Flags any adjacent pair where the lower-indexed word is strictly greater (unsigned).
    function automatic logic order_violation(input logic [NUM*DATA_W-1:0] words);
        logic err;
        err = 1'b0;
        for (int i = 0; i < NUM - 1; i++) begin
            if (words[i*DATA_W +: DATA_W] > words[(i+1)*DATA_W +: DATA_W]) begin
                err = 1'b1;
            end else begin
                err = err;
            end
        end
        return err;
    endfunction

    assign in_flat_s = {number_in8, number_in7, number_in6, number_in5,
                        number_in4, number_in3, number_in2, number_in1};

    assign last_beat_s = (cnt_r == LAST_IDX);

`ifdef SER_DESC_EN
    assign rd_idx_s = LAST_IDX - cnt_r;
`else
    assign rd_idx_s = cnt_r;
`endif

    // Next-state, beat counter and input-side handshake.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        in_ready_s = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    capture_s = 1'b1;
                    cnt_s     = {IDX_W{1'b0}};
                    state_s   = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_beat_s) begin
                        // Final beat frees the buffer in the same cycle, allowing zero-bubble reload.
                        in_ready_s = 1'b1;
                        cnt_s      = {IDX_W{1'b0}};
                        if (in_valid) begin
                            capture_s = 1'b1;
                            state_s   = SEND;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + IDX_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, counter, vector buffer and per-vector order flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {IDX_W{1'b0}};
            sort_err_r <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                buf_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (capture_s) begin
                for (int i = 0; i < NUM; i++) begin
                    buf_r[i] <= in_flat_s[i*DATA_W +: DATA_W];
                end
                sort_err_r <= order_violation(in_flat_s);
            end else if (state_s == IDLE) begin
                sort_err_r <= 1'b0;
            end else begin
                sort_err_r <= sort_err_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == SEND);
    assign number_out = (state_r == SEND) ? buf_r[rd_idx_s] : {DATA_W{1'b0}};
    assign out_idx    = (state_r == SEND) ? cnt_r : {IDX_W{1'b0}};
    assign out_last   = (state_r == SEND) && last_beat_s;
    assign sort_err   = sort_err_r;

endmodule

// File: tb/tb_bitonic_out_serializer.sv
// Directed self-checking bench for bitonic_out_serializer; follows SER_DESC_EN for expected word order.
module tb_bitonic_out_serializer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] number_in1, number_in2, number_in3, number_in4;
    logic [7:0] number_in5, number_in6, number_in7, number_in8;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] number_out;
    logic [2:0] out_idx;
    logic       out_last;
    logic       sort_err;

    logic [7:0][7:0] vec;
    int checks;
    int errors;

    bitonic_out_serializer #(.DATA_W(8), .NUM(8), .IDX_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .number_in1(number_in1), .number_in2(number_in2),
        .number_in3(number_in3), .number_in4(number_in4),
        .number_in5(number_in5), .number_in6(number_in6),
        .number_in7(number_in7), .number_in8(number_in8),
        .out_valid(out_valid), .out_ready(out_ready),
        .number_out(number_out), .out_idx(out_idx),
        .out_last(out_last), .sort_err(sort_err)
    );

    assign number_in1 = vec[0];
    assign number_in2 = vec[1];
    assign number_in3 = vec[2];
    assign number_in4 = vec[3];
    assign number_in5 = vec[4];
    assign number_in6 = vec[5];
    assign number_in7 = vec[6];
    assign number_in8 = vec[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_word(input logic [7:0][7:0] v, input int j);
`ifdef SER_DESC_EN
        return v[7-j];
`else
        return v[j];
`endif
    endfunction

    task automatic set_vec(input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 8; i++) vec[i] = base + 8'(i) * step;
    endtask

    // Check one beat (expected word j of ev, expected sort_err se).
    task automatic check_beat(input string name, input logic [7:0][7:0] ev, input int j, input logic se);
        checks++;
        if (out_valid !== 1'b1 || number_out !== exp_word(ev, j) || out_idx !== 3'(j)
            || out_last !== (j == 7) || sort_err !== se) begin
            errors++;
            $display("FAIL %s beat %0d: got valid=%0b word=%0d idx=%0d last=%0b err=%0b, want valid=1 word=%0d idx=%0d last=%0b err=%0b",
                     name, j, out_valid, number_out, out_idx, out_last, sort_err,
                     exp_word(ev, j), j, (j == 7), se);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sort_err !== 1'b0 || out_last !== 1'b0
            || out_idx !== 3'd0 || number_out !== 8'd0) begin
            errors++;
            $display("FAIL %s: got valid=%0b ready=%0b err=%0b last=%0b idx=%0d word=%0d, want 0 1 0 0 0 0",
                     name, out_valid, in_ready, sort_err, out_last, out_idx, number_out);
        end
    endtask

    // Accept vec at the next edge, then stream all 8 beats with out_ready high.
    task automatic stream_full(input string name, input logic se);
        logic [7:0][7:0] ev;
        ev = vec;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check_beat(name, ev, j, se);
            if (j < 7) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready mid-vector beat %0d: got %0b want 0", name, j, in_ready);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_vec(8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset_state");
    endtask

    task automatic test_ascending();
        set_vec(8'd1, 8'd1);
        stream_full("ascending", 1'b0);
        check_idle("ascending_idle");
    endtask

    task automatic test_stall();
        logic [7:0][7:0] ev;
        int beat;
        set_vec(8'd1, 8'd1);
        ev = vec;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            out_ready = (c % 2 == 0);
            check_beat("stall", ev, beat, 1'b0);
            if (out_ready) beat++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (beat !== 8) begin
            errors++;
            $display("FAIL stall_transfers: got %0d want 8", beat);
        end
        check_idle("stall_idle");
    endtask

    task automatic test_back_to_back();
        logic [7:0][7:0] ev1;
        logic [7:0][7:0] ev2;
        set_vec(8'd1, 8'd1);
        ev1 = vec;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            check_beat("b2b_first", ev1, j, 1'b0);
            @(negedge clk);
        end
        set_vec(8'd10, 8'd1);
        ev2 = vec;
        in_valid = 1'b1;
        check_beat("b2b_first", ev1, 7, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_ready_last: got %0b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check_beat("b2b_second", ev2, j, 1'b0);
            @(negedge clk);
        end
        check_idle("b2b_idle");
    endtask

    task automatic test_sort_err();
        vec[0] = 8'd5;
        vec[1] = 8'd3;
        for (int i = 2; i < 8; i++) vec[i] = 8'd9;
        stream_full("sort_err", 1'b1);
        check_idle("sort_err_idle");
        // Equal neighbours and a 255 top word are still non-decreasing.
        for (int i = 0; i < 7; i++) vec[i] = 8'd4;
        vec[7] = 8'd255;
        stream_full("sort_err_equal", 1'b0);
        check_idle("sort_err_equal_idle");
    endtask

    task automatic test_reset_mid();
        logic [7:0][7:0] ev;
        vec[0] = 8'd5;
        vec[1] = 8'd3;
        for (int i = 2; i < 8; i++) vec[i] = 8'd9;
        ev = vec;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check_beat("reset_mid_pre", ev, j, 1'b1);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset_mid_after");
        @(negedge clk);
        check_idle("reset_mid_quiet");
        set_vec(8'd20, 8'd2);
        stream_full("reset_mid_fresh", 1'b0);
        check_idle("reset_mid_fresh_idle");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        vec = '0;
        @(negedge clk);
        test_reset();
        test_ascending();
        test_stall();
        test_back_to_back();
        test_sort_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
